// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: the WB stage and a one-entry buffer for
// long-latency results share the port, and a scoreboard tracks pending destinations.
module rf_wb_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 4
) (
    input  logic        Clk_CPU,
    input  logic        rstn,
    input  logic        pipe_wr_en,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_wd,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_wd,
    output logic        lu_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        issue_rd_busy,
    output logic        stall_req,
    output logic        RFWr,
    output logic [4:0]  A3,
    output logic [31:0] WD
);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wd;
    } wb_ent_t;

    logic             hold_valid_q, hold_valid_d;
    wb_ent_t          hold_q, hold_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]      busy_q, busy_d;
    logic             rfwr_q, rfwr_d;
    logic [4:0]       a3_q, a3_d;
    logic [31:0]      wd_q, wd_d;
    logic             src_hold_q, src_hold_d;

    logic pipe_req, hold_gnt, lu_acc;

    assign pipe_req = pipe_wr_en && (pipe_rd != 5'd0);
    assign hold_gnt = hold_valid_q && !pipe_req;
    assign lu_acc   = lu_valid && !hold_valid_q;

    assign lu_ready      = ~hold_valid_q;
    assign stall_req     = hold_valid_q && (wait_cnt_q == CNT_W'(STARVE_MAX));
    assign rs1_busy      = busy_q[rs1];
    assign rs2_busy      = busy_q[rs2];
    assign issue_rd_busy = busy_q[issue_rd];
    assign RFWr          = rfwr_q;
    assign A3            = a3_q;
    assign WD            = wd_q;

    always_comb begin
        rfwr_d       = 1'b0;
        a3_d         = a3_q;
        wd_d         = wd_q;
        src_hold_d   = 1'b0;
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        wait_cnt_d   = '0;
        busy_d       = busy_q;

        // A granted hold entry for x0 only frees the buffer.
        if (pipe_req) begin
            rfwr_d = 1'b1;
            a3_d   = pipe_rd;
            wd_d   = pipe_wd;
        end else if (hold_gnt && (hold_q.rd != 5'd0)) begin
            rfwr_d     = 1'b1;
            a3_d       = hold_q.rd;
            wd_d       = hold_q.wd;
            src_hold_d = 1'b1;
        end

        if (hold_gnt)
            hold_valid_d = 1'b0;
        if (lu_acc) begin
            hold_valid_d = 1'b1;
            hold_d       = '{rd: lu_rd, wd: lu_wd};
        end

        if (hold_valid_q && pipe_req)
            wait_cnt_d = (wait_cnt_q == CNT_W'(STARVE_MAX)) ? wait_cnt_q : wait_cnt_q + 1'b1;

        // Clear before set so a same-edge reissue keeps the register pending.
        if (rfwr_q && src_hold_q)
            busy_d[a3_q] = 1'b0;
        if (issue_valid && (issue_rd != 5'd0))
            busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge Clk_CPU or negedge rstn) begin
        if (!rstn) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
            wait_cnt_q   <= '0;
            busy_q       <= '0;
            rfwr_q       <= 1'b0;
            a3_q         <= '0;
            wd_q         <= '0;
            src_hold_q   <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
            wait_cnt_q   <= wait_cnt_d;
            busy_q       <= busy_d;
            rfwr_q       <= rfwr_d;
            a3_q         <= a3_d;
            wd_q         <= wd_d;
            src_hold_q   <= src_hold_d;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios with literal expectations, then
// random traffic obeying the hazard-unit contract, all checked against a queue-based model.
module tb_rf_wb_arbiter;
    localparam int STARVE_MAX = 4;

    logic        Clk_CPU = 1'b0;
    logic        rstn = 1'b0;
    logic        pipe_wr_en = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [31:0] pipe_wd = '0;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_rd = '0;
    logic [31:0] lu_wd = '0;
    logic        lu_ready;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        rs1_busy, rs2_busy, issue_rd_busy, stall_req, RFWr;
    logic [4:0]  A3;
    logic [31:0] WD;

    rf_wb_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(4)) dut (
        .Clk_CPU(Clk_CPU), .rstn(rstn),
        .pipe_wr_en(pipe_wr_en), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_wd(lu_wd), .lu_ready(lu_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .issue_rd_busy(issue_rd_busy), .stall_req(stall_req),
        .RFWr(RFWr), .A3(A3), .WD(WD)
    );

    always #5 Clk_CPU = ~Clk_CPU;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: buffered result as a queue, pending set as a bit array,
    // plus the last committed write and who produced it.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
    } ent_t;
    ent_t        m_hold[$];
    bit          m_busy[32];
    bit          m_rfwr = 0;
    bit          m_from_lu = 0;
    logic [4:0]  m_a3 = '0;
    logic [31:0] m_wd = '0;
    int          m_lost = 0;

    function automatic bit m_stall();
        return (m_hold.size() != 0) && (m_lost == STARVE_MAX);
    endfunction

    initial begin
        forever begin
            @(posedge Clk_CPU or negedge rstn);
            if (!rstn) begin
                m_hold.delete();
                foreach (m_busy[i]) m_busy[i] = 0;
                m_rfwr = 0; m_from_lu = 0; m_a3 = '0; m_wd = '0; m_lost = 0;
            end else begin
                bit   had_hold, pipe_wins, clr;
                logic [4:0] clr_rd;
                ent_t e;
                had_hold  = m_hold.size() != 0;
                pipe_wins = pipe_wr_en && pipe_rd != 0;
                clr       = m_rfwr && m_from_lu;
                clr_rd    = m_a3;
                m_lost    = (had_hold && pipe_wins) ? ((m_lost + 1 > STARVE_MAX) ? STARVE_MAX : m_lost + 1) : 0;
                m_rfwr = 0; m_from_lu = 0;
                if (pipe_wins) begin
                    m_rfwr = 1; m_a3 = pipe_rd; m_wd = pipe_wd;
                end else if (had_hold) begin
                    e = m_hold.pop_front();
                    if (e.rd != 0) begin
                        m_rfwr = 1; m_from_lu = 1; m_a3 = e.rd; m_wd = e.wd;
                    end
                end
                if (lu_valid && !had_hold) begin
                    e.rd = lu_rd; e.wd = lu_wd;
                    m_hold.push_back(e);
                end
                if (clr) m_busy[clr_rd] = 0;
                if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clk_CPU);
            chk("lu_ready", {31'd0, lu_ready}, {31'd0, m_hold.size() == 0});
            chk("stall_req", {31'd0, stall_req}, {31'd0, m_stall()});
            chk("RFWr", {31'd0, RFWr}, {31'd0, m_rfwr});
            chk("A3", {27'd0, A3}, {27'd0, m_a3});
            chk("WD", WD, m_wd);
            chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, m_busy[rs1]});
            chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, m_busy[rs2]});
            chk("issue_rd_busy", {31'd0, issue_rd_busy}, {31'd0, m_busy[issue_rd]});
        end
    end

    bit prev_stall = 0;

    task automatic step();
        prev_stall = m_stall();
        @(posedge Clk_CPU);
        #1;
    endtask

    task automatic idle();
        pipe_wr_en = 0; lu_valid = 0; issue_valid = 0;
    endtask

    logic [4:0] pend[$];

    initial begin
        repeat (2) step();
        chk("rst_lu_ready", {31'd0, lu_ready}, 32'd1);
        chk("rst_RFWr", {31'd0, RFWr}, 32'd0);
        rstn = 1;
        step();

        // Plain pipeline write: visible one cycle later, for one cycle.
        pipe_wr_en = 1; pipe_rd = 5; pipe_wd = 32'h1234;
        step(); idle();
        chk("d1_RFWr", {31'd0, RFWr}, 32'd1);
        chk("d1_A3", {27'd0, A3}, 32'd5);
        chk("d1_WD", WD, 32'h1234);
        chk("d1_lu_ready", {31'd0, lu_ready}, 32'd1);
        step();
        chk("d1_RFWr_off", {31'd0, RFWr}, 32'd0);

        // Long-latency result through the buffer with an idle pipeline.
        issue_valid = 1; issue_rd = 7; rs1 = 7;
        step(); idle();
        chk("d2_busy_set", {31'd0, rs1_busy}, 32'd1);
        lu_valid = 1; lu_rd = 7; lu_wd = 32'hCAFE;
        step(); idle();
        chk("d2_lu_ready_low", {31'd0, lu_ready}, 32'd0);
        step();
        chk("d2_RFWr", {31'd0, RFWr}, 32'd1);
        chk("d2_A3", {27'd0, A3}, 32'd7);
        chk("d2_WD", WD, 32'hCAFE);
        chk("d2_no_bypass", {31'd0, rs1_busy}, 32'd1);
        chk("d2_lu_ready_back", {31'd0, lu_ready}, 32'd1);
        step();
        chk("d2_busy_clear", {31'd0, rs1_busy}, 32'd0);

        // Starvation: pipeline writes every cycle until stall_req, then one bubble.
        issue_valid = 1; issue_rd = 10; rs1 = 10;
        step(); idle();
        lu_valid = 1; lu_rd = 10; lu_wd = 32'hBEEF;
        pipe_wr_en = 1; pipe_rd = 3; pipe_wd = 32'h33;
        step(); lu_valid = 0;
        for (int i = 0; i < STARVE_MAX; i++) begin
            chk("d3_no_stall_yet", {31'd0, stall_req}, 32'd0);
            pipe_wd = 32'h40 + i;
            step();
        end
        chk("d3_stall", {31'd0, stall_req}, 32'd1);
        step(); pipe_wr_en = 0;
        chk("d3_stall_held", {31'd0, stall_req}, 32'd1);
        step();
        chk("d3_hold_RFWr", {31'd0, RFWr}, 32'd1);
        chk("d3_hold_A3", {27'd0, A3}, 32'd10);
        chk("d3_stall_off", {31'd0, stall_req}, 32'd0);
        step();

        // Simultaneous pipeline and long-latency result: pipeline first.
        issue_valid = 1; issue_rd = 9; rs1 = 9;
        step(); idle();
        pipe_wr_en = 1; pipe_rd = 3; pipe_wd = 32'h3;
        lu_valid = 1; lu_rd = 9; lu_wd = 32'h9;
        step(); idle();
        chk("d4_pipe_first", {27'd0, A3}, 32'd3);
        step();
        chk("d4_lu_second", {27'd0, A3}, 32'd9);
        chk("d4_busy_held", {31'd0, rs1_busy}, 32'd1);
        step();
        chk("d4_busy_clear", {31'd0, rs1_busy}, 32'd0);

        // x0 from both sources: no writes, buffer frees after one cycle.
        rs1 = 0;
        pipe_wr_en = 1; pipe_rd = 0; pipe_wd = 32'hDEAD;
        lu_valid = 1; lu_rd = 0; lu_wd = 32'hF00D;
        step(); idle();
        chk("d5_RFWr0", {31'd0, RFWr}, 32'd0);
        chk("d5_lu_ready_low", {31'd0, lu_ready}, 32'd0);
        step();
        chk("d5_RFWr0b", {31'd0, RFWr}, 32'd0);
        chk("d5_lu_ready", {31'd0, lu_ready}, 32'd1);
        chk("d5_x0_busy", {31'd0, rs1_busy}, 32'd0);

        // Asynchronous reset with a buffered result and a pending register.
        issue_valid = 1; issue_rd = 12; rs1 = 12;
        step(); idle();
        pipe_wr_en = 1; pipe_rd = 3; lu_valid = 1; lu_rd = 12; lu_wd = 32'h12;
        step(); lu_valid = 0;
        chk("d6_pre_busy", {31'd0, rs1_busy}, 32'd1);
        chk("d6_pre_lu_ready", {31'd0, lu_ready}, 32'd0);
        #2 rstn = 0;
        #1;
        chk("d6_rst_lu_ready", {31'd0, lu_ready}, 32'd1);
        chk("d6_rst_RFWr", {31'd0, RFWr}, 32'd0);
        chk("d6_rst_busy", {31'd0, rs1_busy}, 32'd0);
        idle();
        step(); step();
        rstn = 1;
        step();

        // Random traffic respecting the hazard-unit contract.
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] r;
            idle();
            pipe_wr_en = !prev_stall && ($urandom_range(0, 3) != 0);
            r = 5'($urandom_range(0, 31));
            while (m_busy[r]) r = 5'($urandom_range(0, 31));
            pipe_rd = r; pipe_wd = $urandom;
            r = 5'($urandom_range(0, 31));
            while (m_busy[r]) r = 5'($urandom_range(0, 31));
            issue_rd = r;
            issue_valid = (pend.size() < 4) && ($urandom_range(0, 2) == 0);
            if (issue_valid && r != 0) pend.push_back(r);
            if (m_hold.size() == 0 && pend.size() > 1 && $urandom_range(0, 1) == 1) begin
                lu_valid = 1; lu_rd = pend.pop_front(); lu_wd = $urandom;
            end else if ($urandom_range(0, 7) == 0) begin
                lu_valid = 1; lu_wd = $urandom;
                lu_rd = (m_hold.size() == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            end
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            step();
        end
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
